rs_dec_msg_framer_16_8: RTL and testbench

- Output stage downstream of the RS(16,8) decoder top, fed directly by its corrected-symbol stream (symb_out_val / symb_out_cnt / symb_corrected).
- Strips the 8 parity symbols and re-frames the 8 message symbols with sop/eop.
- Buffers the result in a small FIFO behind a valid/ready handshake, so a stalling sink does not lose data.
- Tracks sequence errors, overflow and delivered frame count.

---
 rtl/rs_dec_msg_framer_16_8.sv | 163 ++++++++++++++++
 tb/tb_rs_dec_msg_framer_16_8.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_dec_msg_framer_16_8.sv
// rs_dec_msg_framer_16_8: strips RS(16,8) parity and re-frames the message
// symbols with sop/eop into a registered-output FIFO behind valid/ready.
module rs_dec_msg_framer_16_8 #(
    parameter int SYM_BW     = 8,
    parameter int N_NUM      = 16,
    parameter int K_NUM      = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        symb_in_val,
    input  logic [7:0]                  symb_in_cnt,
    input  logic [SYM_BW-1:0]           symb_in,
    input  logic                        dout_rdy,
    output logic                        dout_val,
    output logic [SYM_BW-1:0]           dout,
    output logic                        dout_sop,
    output logic                        dout_eop,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 frame_cnt,
    output logic                        seq_err,
    output logic                        ovf,
    input  logic                        ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = SYM_BW + 2;
    localparam logic [7:0] K_LAST = 8'(K_NUM - 1);
    localparam logic [7:0] N_LAST = 8'(N_NUM - 1);
    localparam logic       K_ONE  = (K_NUM == 1);

    typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

    state_t            state, state_nxt;
    logic [7:0]        exp_cnt, exp_nxt;
    logic              wr_req, wr_sop, wr_eop;
    logic              err_nxt, frame_inc, start;

    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr, rd_nxt;
    logic [LW-1:0]     level_nxt;
    logic [EW-1:0]     wdata, head_nxt;
    logic              pop, push, ovf_ev;

    // Index tracking: decide what to do with the incoming symbol
    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_cnt;
        wr_req    = 1'b0;
        wr_sop    = 1'b0;
        wr_eop    = 1'b0;
        err_nxt   = 1'b0;
        frame_inc = 1'b0;
        start     = 1'b0;
        if (symb_in_val) begin
            unique case (state)
                IDLE: begin
                    if (symb_in_cnt == 8'd0) begin
                        start = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                MSG: begin
                    if (symb_in_cnt == exp_cnt) begin
                        wr_req  = 1'b1;
                        exp_nxt = exp_cnt + 8'd1;
                        if (symb_in_cnt == K_LAST) begin
                            wr_eop    = 1'b1;
                            frame_inc = 1'b1;
                            state_nxt = PAR;
                        end
                    end else begin
                        err_nxt   = 1'b1;
                        start     = (symb_in_cnt == 8'd0);
                        state_nxt = IDLE;
                    end
                end
                PAR: begin
                    if (symb_in_cnt == exp_cnt) begin
                        exp_nxt = exp_cnt + 8'd1;
                        if (symb_in_cnt == N_LAST) begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        err_nxt   = 1'b1;
                        start     = (symb_in_cnt == 8'd0);
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (start) begin
                wr_req    = 1'b1;
                wr_sop    = 1'b1;
                wr_eop    = K_ONE;
                frame_inc = K_ONE;
                exp_nxt   = 8'd1;
                state_nxt = K_ONE ? PAR : MSG;
            end
        end
    end

    // FIFO control; an empty (or just-drained) buffer forwards the write
    always_comb begin
        pop       = dout_val & dout_rdy;
        push      = wr_req & ((fifo_level != LW'(FIFO_DEPTH)) | pop);
        ovf_ev    = wr_req & ~push;
        level_nxt = fifo_level + LW'(push) - LW'(pop);
        rd_nxt    = rd_ptr + AW'(pop);
        wdata     = {wr_sop, wr_eop, symb_in};
        head_nxt  = mem[rd_nxt];
        if (push && ((fifo_level - LW'(pop)) == '0)) begin
            head_nxt = wdata;
        end
    end

    // Buffer storage needs no reset; occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Framer state, status flags, pointers and registered output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            exp_cnt    <= 8'd0;
            seq_err    <= 1'b0;
            frame_cnt  <= 16'd0;
            ovf        <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            dout_val   <= 1'b0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
            dout       <= '0;
        end else begin
            state      <= state_nxt;
            exp_cnt    <= exp_nxt;
            seq_err    <= err_nxt;
            frame_cnt  <= frame_cnt + 16'(frame_inc);
            if (ovf_ev) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_nxt;
            fifo_level <= level_nxt;
            dout_val   <= (level_nxt != '0);
            if (level_nxt != '0) begin
                {dout_sop, dout_eop, dout} <= head_nxt;
            end
        end
    end

endmodule

// File: tb/tb_rs_dec_msg_framer_16_8.sv
// tb_rs_dec_msg_framer_16_8: randomized + directed bench with a
// position-based reference model feeding a scoreboard queue.
module tb_rs_dec_msg_framer_16_8;

    localparam int N     = 16;
    localparam int K     = 8;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       symb_in_val = 1'b0;
    logic [7:0] symb_in_cnt = 8'd0;
    logic [7:0] symb_in = 8'd0;
    logic       dout_rdy = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       dout_val, dout_sop, dout_eop, seq_err, ovf;
    logic [7:0] dout;
    logic [4:0] fifo_level;
    logic [15:0] frame_cnt;

    rs_dec_msg_framer_16_8 dut (
        .clk(clk), .rst_n(rst_n),
        .symb_in_val(symb_in_val), .symb_in_cnt(symb_in_cnt),
        .symb_in(symb_in), .dout_rdy(dout_rdy),
        .dout_val(dout_val), .dout(dout),
        .dout_sop(dout_sop), .dout_eop(dout_eop),
        .fifo_level(fifo_level), .frame_cnt(frame_cnt),
        .seq_err(seq_err), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [9:0] sb[$];
    logic [9:0] mon_e;
    int exp_seq = 0;
    int obs_seq = 0;
    int exp_frames = 0;
    int pops = 0;
    bit exp_ovf = 1'b0;
    bit in_sync = 1'b0;
    int run = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: pop expected entries on every handshake, count seq_err pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (seq_err) obs_seq++;
            if (dout_val && dout_rdy) begin
                pops++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", int'({dout_sop, dout_eop, dout}), -1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("dout_sop_eop_data", int'({dout_sop, dout_eop, dout}), int'(mon_e));
                end
            end
        end
    end

    // Reference: position within the current in-order run of indices
    task automatic model(input bit v, input logic [7:0] c, input logic [7:0] d);
        bit pop, wr, s, e, ev;
        pop = (sb.size() > 0) && dout_rdy;
        wr = 0; s = 0; e = 0; ev = 0;
        if (v) begin
            if (c == 8'd0) begin
                if (in_sync) exp_seq++;
                in_sync = 1; run = 1; wr = 1; s = 1; e = (K == 1);
            end else if (in_sync && int'(c) == run) begin
                wr = (int'(c) < K);
                e = (int'(c) == K - 1);
                run++;
                if (run == N) in_sync = 0;
            end else begin
                exp_seq++;
                in_sync = 0;
            end
            if (wr && e) exp_frames++;
            if (wr) begin
                if (sb.size() >= DEPTH && !pop) ev = 1;
                else sb.push_back({s, e, d});
            end
        end
        if (ev) exp_ovf = 1;
        else if (ovf_clr) exp_ovf = 0;
    endtask

    task automatic step(input bit v, input logic [7:0] c, input logic [7:0] d);
        symb_in_val = v;
        symb_in_cnt = c;
        symb_in = d;
        model(v, c, d);
        @(posedge clk);
        #1;
        symb_in_val = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0);
    endtask

    task automatic frame(input logic [7:0] base);
        for (int i = 0; i < N; i++) step(1'b1, 8'(i), base + 8'(i));
    endtask

    task automatic model_reset();
        sb.delete();
        in_sync = 0; run = 0; exp_ovf = 0; exp_frames = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout_val"}, int'(dout_val), 0);
        chk({tag, "_dout"}, int'(dout), 0);
        chk({tag, "_sop"}, int'(dout_sop), 0);
        chk({tag, "_eop"}, int'(dout_eop), 0);
        chk({tag, "_level"}, int'(fifo_level), 0);
        chk({tag, "_frame_cnt"}, int'(frame_cnt), 0);
        chk({tag, "_seq_err"}, int'(seq_err), 0);
        chk({tag, "_ovf"}, int'(ovf), 0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_zero("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_level"}, int'(fifo_level), sb.size());
        chk({tag, "_frame_cnt"}, int'(frame_cnt), exp_frames);
        chk({tag, "_ovf"}, int'(ovf), int'(exp_ovf));
        chk({tag, "_seq_cnt"}, obs_seq, exp_seq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int s0, p0, pos, r;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // clean frame, first output right after the cnt 0 edge
        dout_rdy = 1'b1;
        chk("no_bypass_val", int'(dout_val), 0);
        step(1'b1, 8'd0, 8'hA0);
        chk("first_val", int'(dout_val), 1);
        chk("first_data", int'(dout), 'hA0);
        chk("first_sop", int'(dout_sop), 1);
        for (int i = 1; i < N; i++) step(1'b1, 8'(i), 8'hA0 + 8'(i));
        idle(3);
        chk("clean_frame_cnt", int'(frame_cnt), 1);
        chk("clean_seq", obs_seq, 0);
        chk_state("clean");

        // backpressure with overflow on third frame
        idle(1);
        do_reset();
        dout_rdy = 1'b0;
        frame(8'h10);
        frame(8'h20);
        chk("bp_level_full", int'(fifo_level), 16);
        chk("bp_no_ovf", int'(ovf), 0);
        frame(8'h30);
        chk("bp_ovf", int'(ovf), 1);
        chk("bp_frame_cnt", int'(frame_cnt), 3);
        dout_rdy = 1'b1;
        p0 = pops;
        idle(20);
        chk("bp_drained", pops - p0, 16);
        chk_state("bp");

        // sequence error 0,1,2,5 then a good frame
        s0 = obs_seq;
        step(1'b1, 8'd0, 8'h40);
        step(1'b1, 8'd1, 8'h41);
        step(1'b1, 8'd2, 8'h42);
        step(1'b1, 8'd5, 8'h45);
        idle(2);
        chk("seq_err_once", obs_seq - s0, 1);
        frame(8'h50);
        idle(3);
        chk("seq_err_idle", obs_seq - s0, 1);
        chk("seq_sb_empty", sb.size(), 0);

        // restart mid message
        s0 = obs_seq;
        step(1'b1, 8'd0, 8'h60);
        step(1'b1, 8'd1, 8'h61);
        step(1'b1, 8'd2, 8'h62);
        frame(8'h68);
        idle(3);
        chk("restart_seq_err", obs_seq - s0, 1);
        chk_state("restart");

        // full FIFO with simultaneous push and pop
        ovf_clr = 1'b1;
        step(1'b0, 8'd0, 8'd0);
        ovf_clr = 1'b0;
        chk("ovf_cleared", int'(ovf), 0);
        dout_rdy = 1'b0;
        frame(8'h70);
        frame(8'h80);
        chk("pp_level_full", int'(fifo_level), 16);
        dout_rdy = 1'b1;
        step(1'b1, 8'd0, 8'h90);
        chk("pp_level_held", int'(fifo_level), 16);
        chk("pp_no_ovf", int'(ovf), 0);
        for (int i = 1; i < N; i++) step(1'b1, 8'(i), 8'h90 + 8'(i));
        idle(20);
        chk_state("pushpop");

        // ovf_clr colliding with an overflow
        dout_rdy = 1'b0;
        frame(8'hB0);
        frame(8'hC0);
        ovf_clr = 1'b1;
        step(1'b1, 8'd0, 8'hD0);
        ovf_clr = 1'b0;
        chk("clr_vs_set", int'(ovf), 1);
        for (int i = 1; i < N; i++) step(1'b1, 8'(i), 8'hD0 + 8'(i));
        ovf_clr = 1'b1;
        step(1'b0, 8'd0, 8'd0);
        ovf_clr = 1'b0;
        chk("clr_alone", int'(ovf), 0);
        dout_rdy = 1'b1;
        idle(20);
        chk_state("clr");

        // async reset with five symbols buffered
        dout_rdy = 1'b0;
        for (int i = 0; i < 5; i++) step(1'b1, 8'(i), 8'hE0 + 8'(i));
        chk("pre_rst_level", int'(fifo_level), 5);
        do_reset();
        dout_rdy = 1'b1;
        frame(8'hF0);
        idle(3);
        chk("post_rst_frames", int'(frame_cnt), 1);
        chk_state("post_rst");

        // randomized traffic with errors, stalls and clears
        pos = 0;
        for (int n = 0; n < 600; n++) begin
            dout_rdy = ($urandom_range(0, 9) < 6);
            ovf_clr = ($urandom_range(0, 39) == 0);
            r = $urandom_range(0, 99);
            if (r < 6) begin
                step(1'b0, 8'd0, 8'd0);
            end else if (r < 11) begin
                pos = $urandom_range(0, N - 1);
                step(1'b1, 8'(pos), 8'($urandom));
                pos = (pos + 1) % N;
            end else begin
                step(1'b1, 8'(pos), 8'($urandom));
                pos = (pos + 1) % N;
            end
        end
        ovf_clr = 1'b0;
        dout_rdy = 1'b1;
        idle(24);
        chk("rand_sb_empty", sb.size(), 0);
        chk_state("random");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
